// File: rtl/scp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scp_pkg
// Brief   : Shared widths, colour codes, scp_079 state encodings and the
//           colour priority resolver used by scp_timer_gen.
// Revision: 1.0
// ============================================================================
package scp_pkg;

    localparam int STATE_W = 3;
    localparam int TIMER_W = 6;

    localparam logic [2:0] C_GREEN  = 3'b001;
    localparam logic [2:0] C_YELLOW = 3'b010;
    localparam logic [2:0] C_RED    = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT       = 3'd0,
        ST_GREEN      = 3'd1,
        ST_YELLOW     = 3'd2,
        ST_RED        = 3'd3,
        ST_RED_YELLOW = 3'd4,
        ST_FLASH      = 3'd5,
        ST_FAULT      = 3'd6
    } scp_state_e;

    // Clean one-hot passes through; all-zero keeps the held colour;
    // multi-bit codes resolve red > yellow > green.
    function automatic logic [2:0] resolve_colour(input logic [2:0] code,
                                                  input logic [2:0] held);
        logic [2:0] result;
        case (code)
            C_GREEN, C_YELLOW, C_RED: result = code;
            3'b000:                   result = held;
            default: begin
                if (code[2])      result = C_RED;
                else if (code[1]) result = C_YELLOW;
                else              result = C_GREEN;
            end
        endcase
        return result;
    endfunction

endpackage : scp_pkg
`default_nettype wire

// File: rtl/scp_color_debounce.sv
`default_nettype none
// ============================================================================
// Module  : scp_color_debounce
// Brief   : Two-flop synchronizer, one-hot resolve and debounce of the raw
//           {red, yellow, green} sensor lines.
// Revision: 1.0
// ============================================================================
module scp_color_debounce
    import scp_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] color_raw,
    output logic [2:0] color_out
);

    localparam logic [3:0] c_CNT_LAST = 4'(DEBOUNCE - 1);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_color;
    logic [3:0] r_cnt;
    logic [2:0] w_cand;
    logic       w_differs;

    // Synchronizer resets to green so the resolved output is one-hot from reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= C_GREEN;
            r_sync2 <= C_GREEN;
        end else begin
            r_sync1 <= color_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_cand    = resolve_colour(r_sync2, r_color);
        w_differs = (w_cand != r_color);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_color <= C_GREEN;
            r_cnt   <= 4'd0;
        end else if (w_differs) begin
            if (r_cnt == c_CNT_LAST) begin
                r_color <= w_cand;
                r_cnt   <= 4'd0;
            end else begin
                r_cnt   <= r_cnt + 4'd1;
            end
        end else begin
            r_cnt <= 4'd0;
        end
    end

    assign color_out = r_color;

endmodule : scp_color_debounce
`default_nettype wire

// File: rtl/scp_timer_gen.sv
`default_nettype none
// ============================================================================
// Module  : scp_timer_gen
// Brief   : Per-state tick timer with automatic restart on scp_079 state
//           change, plus debounced one-hot colour inputs for scp_079.
// Revision: 1.0
// ============================================================================
module scp_timer_gen
    import scp_pkg::*;
#(
    parameter int TIMER_W  = scp_pkg::TIMER_W,
    parameter int STATE_W  = scp_pkg::STATE_W,
    parameter int TICK_DIV = 1,
    parameter int DEBOUNCE = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [STATE_W-1:0] state_in,
    input  logic [2:0]         color_raw,
    output logic [TIMER_W-1:0] timer,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic               state_changed,
    output logic               timer_sat
);

    localparam logic [TIMER_W-1:0] c_TIMER_MAX = '1;

    logic [STATE_W-1:0] r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_state_changed;
    logic               r_timer_sat;
    logic               w_chg;
    logic               w_tick;
    logic [2:0]         w_color;

    assign w_chg = (state_in != r_state);

    if (TICK_DIV == 1) begin : g_tick_every_clock
        assign w_tick = 1'b1;
    end else begin : g_prescaler
        localparam int               c_PRE_W    = $clog2(TICK_DIV);
        localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

        logic [c_PRE_W-1:0] r_prescaler;

        // A state change realigns the prescaler so the new state gets full periods.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_prescaler <= '0;
            end else if (w_chg || (r_prescaler == c_PRE_LAST)) begin
                r_prescaler <= '0;
            end else begin
                r_prescaler <= r_prescaler + c_PRE_W'(1);
            end
        end

        assign w_tick = (r_prescaler == c_PRE_LAST);
    end

    // Restart beats tick, so a tick coinciding with a state change is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= '0;
            r_state_changed <= 1'b0;
            r_timer         <= '0;
            r_timer_sat     <= 1'b0;
        end else begin
            r_state         <= state_in;
            r_state_changed <= w_chg;
            if (w_chg) begin
                r_timer     <= '0;
                r_timer_sat <= 1'b0;
            end else if (w_tick) begin
                if (r_timer != c_TIMER_MAX) begin
                    r_timer <= r_timer + TIMER_W'(1);
                end else begin
                    r_timer_sat <= 1'b1;
                end
            end
        end
    end

    scp_color_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_color_debounce (
        .clock     (clock),
        .reset_n   (reset_n),
        .color_raw (color_raw),
        .color_out (w_color)
    );

    assign timer         = r_timer;
    assign state_changed = r_state_changed;
    assign timer_sat     = r_timer_sat;
    assign green         = w_color[0];
    assign yellow        = w_color[1];
    assign red           = w_color[2];

endmodule : scp_timer_gen
`default_nettype wire

// File: tb/tb_scp_timer_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_scp_timer_gen
// Brief   : Directed self-checking bench for scp_timer_gen (TICK_DIV 1 and 4).
// Revision: 1.0
// ============================================================================
module tb_scp_timer_gen;
    import scp_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] state_in;
    logic [2:0] state_in4;
    logic [2:0] color_raw;

    logic [5:0] timer, timer4;
    logic       green, yellow, red, state_changed, timer_sat;
    logic       green4, yellow4, red4, state_changed4, timer_sat4;
    logic [2:0] rgb;
    logic       sc_seen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign rgb = {red, yellow, green};

    scp_timer_gen #(.TIMER_W(6), .STATE_W(3), .TICK_DIV(1), .DEBOUNCE(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .state_in      (state_in),
        .color_raw     (color_raw),
        .timer         (timer),
        .green         (green),
        .yellow        (yellow),
        .red           (red),
        .state_changed (state_changed),
        .timer_sat     (timer_sat)
    );

    scp_timer_gen #(.TIMER_W(6), .STATE_W(3), .TICK_DIV(4), .DEBOUNCE(2)) dut4 (
        .clock         (clock),
        .reset_n       (reset_n),
        .state_in      (state_in4),
        .color_raw     (color_raw),
        .timer         (timer4),
        .green         (green4),
        .yellow        (yellow4),
        .red           (red4),
        .state_changed (state_changed4),
        .timer_sat     (timer_sat4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Change state, then expect restart + pulse, then n clocks -> timer == n.
    task automatic step_state(input logic [2:0] nxt, input int n);
        state_in = nxt;
        adv(1);
        check("chg_timer0", timer, 0);
        check("chg_pulse", state_changed, 1);
        adv(1);
        check("chg_pulse_end", state_changed, 0);
        adv(n - 1);
        check("chg_count", timer, n);
    endtask

    initial begin
        reset_n   = 1'b0;
        state_in  = 3'd0;
        state_in4 = 3'd0;
        color_raw = 3'b001;
        adv(2);
        check("rst_timer", timer, 0);
        check("rst_green", green, 1);
        check("rst_yellow", yellow, 0);
        check("rst_red", red, 0);
        check("rst_sc", state_changed, 0);
        check("rst_sat", timer_sat, 0);

        reset_n = 1'b1;
        sc_seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (state_changed) sc_seen = 1'b1;
        end
        check("run35_timer", timer, 35);
        check("run35_rgb", rgb, C_GREEN);
        check("run35_sat", timer_sat, 0);
        check("run35_sc_seen", sc_seen, 0);
        check("run35_div4", timer4, 8);

        step_state(3'd2, 20);
        step_state(3'd3, 9);
        step_state(3'd5, 11);

        state_in = 3'd1;
        adv(1);
        check("sat_start", timer, 0);
        adv(63);
        check("sat_t63", timer, 63);
        check("sat_flag63", timer_sat, 0);
        adv(1);
        check("sat_t64", timer, 63);
        check("sat_flag64", timer_sat, 1);
        adv(15);
        check("sat_t80", timer, 63);
        check("sat_flag80", timer_sat, 1);
        state_in = 3'd4;
        adv(1);
        check("sat_clr_timer", timer, 0);
        check("sat_clr_flag", timer_sat, 0);

        state_in4 = 3'd1;
        adv(1);
        check("div4_restart", timer4, 0);
        adv(12);
        check("div4_12clk", timer4, 3);
        adv(3);
        check("div4_pre_tick", timer4, 3);
        state_in4 = 3'd2;
        adv(1);
        check("div4_chg_on_tick", timer4, 0);
        check("div4_pulse", state_changed4, 1);
        adv(3);
        check("div4_3clk", timer4, 0);
        adv(1);
        check("div4_4clk", timer4, 1);

        color_raw = 3'b100;
        adv(3);
        check("col_red_lat3", rgb, C_GREEN);
        adv(1);
        check("col_red_lat4", rgb, C_RED);

        color_raw = 3'b010;
        adv(1);
        color_raw = 3'b100;
        for (int i = 0; i < 6; i++) begin
            adv(1);
            check("col_glitch", rgb, C_RED);
        end

        color_raw = 3'b001;
        adv(4);
        check("col_back_green", rgb, C_GREEN);
        color_raw = 3'b110;
        adv(3);
        check("col_multi_lat3", rgb, C_GREEN);
        adv(1);
        check("col_multi_red", rgb, C_RED);
        color_raw = 3'b011;
        adv(4);
        check("col_multi_yellow", rgb, C_YELLOW);
        color_raw = 3'b000;
        adv(10);
        check("col_zero_hold", rgb, C_YELLOW);

        color_raw = 3'b100;
        state_in  = 3'd6;
        adv(18);
        check("pre_rst_timer", timer, 17);
        check("pre_rst_rgb", rgb, C_RED);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_timer", timer, 0);
        check("async_rst_rgb", rgb, C_GREEN);
        check("async_rst_sat", timer_sat, 0);
        check("async_rst_sc", state_changed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scp_timer_gen
`default_nettype wire
